// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore sequencer for the multi-cycle MIPS-subset datapath
// (R-type, lw, sw, bne, xori, j) sharing one ALU and one unified memory.
// Memory phases stall on MemReady. The only input-qualified outputs are
// IRWrite/PCEn in FETCH, PCEn in BRANCH, InstrDone in MEMWR and IllegalOp
// in DECODE.
// Optional feature macro: MULTICYCLE_CTRL_PERF_EN adds the CycleCnt and
// RetireCnt performance counters.
module multicycle_ctrl #(
    parameter int OPC_W  = 6,
    parameter int PERF_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [OPC_W-1:0] Opcode,
    input  logic             Zero,
    input  logic             MemReady,
    output logic             PCEn,
    output logic [1:0]       PCSource,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             RegDst,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic             SignZero,
    output logic             InstrDone,
    output logic             IllegalOp
`ifdef MULTICYCLE_CTRL_PERF_EN
    ,
    output logic [PERF_W-1:0] CycleCnt,
    output logic [PERF_W-1:0] RetireCnt
`endif
);

    localparam logic [OPC_W-1:0] OP_RTYPE = OPC_W'(6'b000000);
    localparam logic [OPC_W-1:0] OP_LW    = OPC_W'(6'b100011);
    localparam logic [OPC_W-1:0] OP_SW    = OPC_W'(6'b101011);
    localparam logic [OPC_W-1:0] OP_BNE   = OPC_W'(6'b000101);
    localparam logic [OPC_W-1:0] OP_XORI  = OPC_W'(6'b001110);
    localparam logic [OPC_W-1:0] OP_J     = OPC_W'(6'b000010);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_IEXEC  = 4'd9,
        S_IWB    = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    state_t           state;
    logic [OPC_W-1:0] op_q;

    function automatic logic is_known(input logic [OPC_W-1:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BNE) || (op == OP_XORI) || (op == OP_J);
    endfunction

    // State sequencing; opcode captured in DECODE for the lw/sw split in MEMADR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
            op_q  <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (MemReady) state <= S_DECODE;
                end
                S_DECODE: begin
                    op_q <= Opcode;
                    if (Opcode == OP_RTYPE)                       state <= S_EXEC;
                    else if ((Opcode == OP_LW) || (Opcode == OP_SW)) state <= S_MEMADR;
                    else if (Opcode == OP_BNE)                    state <= S_BRANCH;
                    else if (Opcode == OP_XORI)                   state <= S_IEXEC;
                    else if (Opcode == OP_J)                      state <= S_JUMP;
                    else                                          state <= S_FETCH;
                end
                S_MEMADR: state <= (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
                S_MEMRD: begin
                    if (MemReady) state <= S_MEMWB;
                end
                S_MEMWB:  state <= S_FETCH;
                S_MEMWR: begin
                    if (MemReady) state <= S_FETCH;
                end
                S_EXEC:   state <= S_RWB;
                S_RWB:    state <= S_FETCH;
                S_BRANCH: state <= S_FETCH;
                S_IEXEC:  state <= S_IWB;
                S_IWB:    state <= S_FETCH;
                S_JUMP:   state <= S_FETCH;
                default:  state <= S_FETCH;
            endcase
        end
    end

    // Output decode of the state register; gated by rst_n so that asserting
    // reset silences every control line at once, even mid-instruction.
    always_comb begin
        PCEn      = 1'b0;
        PCSource  = 2'b00;
        IorD      = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        RegDst    = 1'b0;
        MemtoReg  = 1'b0;
        RegWrite  = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        ALUOp     = 2'b00;
        SignZero  = 1'b0;
        InstrDone = 1'b0;
        IllegalOp = 1'b0;
        if (rst_n) begin
            case (state)
                S_FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = 2'b01;
                    IRWrite = MemReady;
                    PCEn    = MemReady;
                end
                S_DECODE: begin
                    ALUSrcB   = 2'b11;
                    IllegalOp = ~is_known(Opcode);
                end
                S_MEMADR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                S_MEMRD: begin
                    IorD    = 1'b1;
                    MemRead = 1'b1;
                end
                S_MEMWB: begin
                    MemtoReg  = 1'b1;
                    RegWrite  = 1'b1;
                    InstrDone = 1'b1;
                end
                S_MEMWR: begin
                    IorD      = 1'b1;
                    MemWrite  = 1'b1;
                    InstrDone = MemReady;
                end
                S_EXEC: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = 2'b10;
                end
                S_RWB: begin
                    RegDst    = 1'b1;
                    RegWrite  = 1'b1;
                    InstrDone = 1'b1;
                end
                S_BRANCH: begin
                    ALUSrcA   = 1'b1;
                    ALUOp     = 2'b01;
                    PCSource  = 2'b01;
                    PCEn      = ~Zero;
                    InstrDone = 1'b1;
                end
                S_IEXEC: begin
                    ALUSrcA  = 1'b1;
                    ALUSrcB  = 2'b10;
                    ALUOp    = 2'b11;
                    SignZero = 1'b1;
                end
                S_IWB: begin
                    RegWrite  = 1'b1;
                    InstrDone = 1'b1;
                end
                S_JUMP: begin
                    PCSource  = 2'b10;
                    PCEn      = 1'b1;
                    InstrDone = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef MULTICYCLE_CTRL_PERF_EN
    // Free-running cycle counter and retired-instruction counter, both wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            CycleCnt  <= '0;
            RetireCnt <= '0;
        end else begin
            CycleCnt <= CycleCnt + PERF_W'(1);
            if (InstrDone) RetireCnt <= RetireCnt + PERF_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-instruction cycle scripts
// with random MemReady stalls, Zero and instruction mix.
module tb_multicycle_ctrl;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_XORI = 6'b001110;
    localparam logic [5:0] OP_J    = 6'b000010;

    typedef struct packed {
        logic       pcen;
        logic [1:0] pcsrc;
        logic       iord;
        logic       mrd;
        logic       mwr;
        logic       irw;
        logic       regdst;
        logic       m2r;
        logic       regw;
        logic       srca;
        logic [1:0] srcb;
        logic [1:0] aluop;
        logic       signz;
        logic       done;
        logic       ill;
    } ctl_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] Opcode;
    logic       Zero;
    logic       MemReady;
    logic       PCEn, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg;
    logic       RegWrite, ALUSrcA, SignZero, InstrDone, IllegalOp;
    logic [1:0] PCSource, ALUSrcB, ALUOp;
`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [31:0] CycleCnt, RetireCnt;
`endif

    int ntests = 0;
    int nfail  = 0;
    int cyc_m  = 0;
    int ret_m  = 0;

    ctl_t obs;
    assign obs = {PCEn, PCSource, IorD, MemRead, MemWrite, IRWrite, RegDst,
                  MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp, SignZero,
                  InstrDone, IllegalOp};

    multicycle_ctrl #(.OPC_W(6), .PERF_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .Zero(Zero), .MemReady(MemReady),
        .PCEn(PCEn), .PCSource(PCSource), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .SignZero(SignZero), .InstrDone(InstrDone), .IllegalOp(IllegalOp)
`ifdef MULTICYCLE_CTRL_PERF_EN
        , .CycleCnt(CycleCnt), .RetireCnt(RetireCnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic legal(input logic [5:0] op);
        return op inside {OP_R, OP_LW, OP_SW, OP_BNE, OP_XORI, OP_J};
    endfunction

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] x);
        ntests++;
        assert (o === x) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, o, x);
        end
    endtask

    // One clock of the script: drive inputs, check at negedge, advance.
    task automatic step(input string tag, input ctl_t e, input logic mr, input logic z);
        MemReady = mr;
        Zero     = z;
        @(negedge clk);
        chk(tag, 32'(obs), 32'(e));
        chk({tag, "_rdwr_excl"}, 32'(MemRead & MemWrite), 32'd0);
`ifdef MULTICYCLE_CTRL_PERF_EN
        chk({tag, "_cyclecnt"}, CycleCnt, 32'(cyc_m));
        chk({tag, "_retirecnt"}, RetireCnt, 32'(ret_m));
`endif
        @(posedge clk);
        #1;
        cyc_m++;
        if (e.done) ret_m++;
    endtask

    // Whole instruction: fl stalled fetch cycles, ml stalled memory cycles.
    task automatic run_instr(input logic [5:0] op, input logic z, input int fl, input int ml);
        ctl_t e;
        Opcode = op;
        for (int i = 0; i <= fl; i++) begin
            e = '0; e.mrd = 1'b1; e.srcb = 2'b01;
            e.irw = (i == fl); e.pcen = (i == fl);
            step("fetch", e, (i == fl), z);
        end
        e = '0; e.srcb = 2'b11; e.ill = ~legal(op);
        step("decode", e, 1'($urandom_range(0, 1)), z);
        case (op)
            OP_R: begin
                e = '0; e.srca = 1'b1; e.aluop = 2'b10;
                step("r_exec", e, 1'b1, z);
                e = '0; e.regdst = 1'b1; e.regw = 1'b1; e.done = 1'b1;
                step("r_wb", e, 1'b1, z);
            end
            OP_LW, OP_SW: begin
                e = '0; e.srca = 1'b1; e.srcb = 2'b10;
                step("memadr", e, 1'b1, z);
                for (int i = 0; i <= ml; i++) begin
                    e = '0; e.iord = 1'b1;
                    if (op == OP_LW) e.mrd = 1'b1;
                    else begin e.mwr = 1'b1; e.done = (i == ml); end
                    step((op == OP_LW) ? "lw_mem" : "sw_mem", e, (i == ml), z);
                end
                if (op == OP_LW) begin
                    e = '0; e.m2r = 1'b1; e.regw = 1'b1; e.done = 1'b1;
                    step("lw_wb", e, 1'b0, z);
                end
            end
            OP_BNE: begin
                e = '0; e.srca = 1'b1; e.aluop = 2'b01; e.pcsrc = 2'b01;
                e.pcen = ~z; e.done = 1'b1;
                step("bne", e, 1'b0, z);
            end
            OP_XORI: begin
                e = '0; e.srca = 1'b1; e.srcb = 2'b10; e.aluop = 2'b11; e.signz = 1'b1;
                step("xori_exec", e, 1'b0, z);
                e = '0; e.regw = 1'b1; e.done = 1'b1;
                step("xori_wb", e, 1'b0, z);
            end
            OP_J: begin
                e = '0; e.pcsrc = 2'b10; e.pcen = 1'b1; e.done = 1'b1;
                step("jump", e, 1'b0, z);
            end
            default: begin
            end
        endcase
    endtask

    initial begin
        ctl_t e;
        logic [5:0] op;
        logic [5:0] ops [6];
        ops = '{OP_R, OP_LW, OP_SW, OP_BNE, OP_XORI, OP_J};
        rst_n = 1'b0; Opcode = '0; Zero = 1'b0; MemReady = 1'b0;
        #1;
        chk("reset_outputs", 32'(obs), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc_m = 0; ret_m = 0;

        // Directed scenarios
        run_instr(OP_R, 1'b0, 0, 0);
        run_instr(OP_LW, 1'b0, 0, 2);
        run_instr(OP_BNE, 1'b0, 0, 0);
        run_instr(OP_BNE, 1'b1, 0, 0);
        run_instr(OP_XORI, 1'b1, 1, 0);
        run_instr(6'b111111, 1'b0, 0, 0);
        run_instr(OP_SW, 1'b0, 2, 1);
        run_instr(OP_J, 1'b1, 0, 0);

        // Random mix including illegal opcodes
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                op = 6'($urandom);
                while (legal(op)) op = 6'($urandom);
            end else begin
                op = ops[$urandom_range(0, 5)];
            end
            run_instr(op, 1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 3));
        end

        // Reset dropped while a store waits on memory
        Opcode = OP_SW;
        e = '0; e.mrd = 1'b1; e.srcb = 2'b01; e.irw = 1'b1; e.pcen = 1'b1;
        step("rst_fetch", e, 1'b1, 1'b0);
        e = '0; e.srcb = 2'b11;
        step("rst_decode", e, 1'b0, 1'b0);
        e = '0; e.srca = 1'b1; e.srcb = 2'b10;
        step("rst_memadr", e, 1'b0, 1'b0);
        e = '0; e.iord = 1'b1; e.mwr = 1'b1;
        step("rst_memwr_wait", e, 1'b0, 1'b0);
        MemReady = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_outputs", 32'(obs), 32'd0);
        @(posedge clk);
        #1;
        chk("rst_held_outputs", 32'(obs), 32'd0);
        rst_n = 1'b1;
        #1;
`ifdef MULTICYCLE_CTRL_PERF_EN
        chk("rst_cyclecnt", CycleCnt, 32'd0);
        chk("rst_retirecnt", RetireCnt, 32'd0);
`endif
        cyc_m = 0; ret_m = 0;
        run_instr(OP_J, 1'b0, 1, 0);
        run_instr(OP_LW, 1'b1, 0, 0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle sequencer for the MIPS-subset datapath: R-type, lw, sw, bne, xori, j.
- Replaces single-cycle decode with a Moore FSM that drives a shared ALU and one unified instruction/data memory.
- Memory accesses use a ready handshake.
- Sits between the instruction register (Opcode), ALU flag (Zero), memory (MemReady) and the datapath muxes and enables.

Parameters:
- OPC_W, 6, opcode width.
- PERF_W, 32, width of optional performance counters.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- Opcode  in  OPC_W  instr[31:26] from instruction register
- Zero  in  1  ALU zero flag
- MemReady  in  1  memory completes current read/write this cycle
- PCEn  out  1  PC register load enable
- PCSource  out  2  00 ALU result, 01 ALUOut (branch target), 10 jump address
- IorD  out  1  0 PC address, 1 ALUOut address
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- IRWrite  out  1  instruction register load
- RegDst  out  1  1 rd, 0 rt
- MemtoReg  out  1  1 MDR, 0 ALUOut
- RegWrite  out  1  register file write
- ALUSrcA  out  1  0 PC, 1 rs
- ALUSrcB  out  2  00 rt, 01 const 4, 10 ext imm, 11 ext imm<<2
- ALUOp  out  2  00 add, 01 sub, 10 funct, 11 xor
- SignZero  out  1  1 zero-extend, 0 sign-extend
- InstrDone  out  1  one-cycle pulse in final state of each instruction
- IllegalOp  out  1  one-cycle pulse on unknown opcode

Behaviour:
- State register is 4 bits. rst_n=0 forces state to FETCH and all outputs to 0 asynchronously, including mid-instruction; any in-flight access is abandoned.
- Outputs not listed for a state are 0.
- FETCH:
  - Outputs: IorD=0, MemRead=1, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite=PCEn=MemReady (Mealy qualifier).
  - Holds until MemReady=1, then goes to DECODE.
- DECODE:
  - Outputs: ALUSrcA=0, ALUSrcB=11, ALUOp=00, SignZero=0.
  - Opcode is latched into op_q.
  - Next state: 000000 EXEC; 100011/101011 MEMADR; 000101 BRANCH; 001110 IEXEC; 000010 JUMP.
  - Any other opcode: IllegalOp=1 this cycle, next state FETCH.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Goes to MEMRD if op_q=lw, else MEMWR.
- MEMRD: IorD=1, MemRead=1. Waits for MemReady, then MEMWB.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1, InstrDone=1. Next state FETCH.
- MEMWR:
  - Outputs: IorD=1, MemWrite=1.
  - Waits for MemReady. InstrDone=MemReady; next state FETCH when MemReady=1.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next state RWB.
- RWB: RegDst=1, RegWrite=1, InstrDone=1. Next state FETCH.
- BRANCH:
  - Outputs: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=01, PCEn=~Zero, InstrDone=1.
  - Next state FETCH.
- IEXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=11, SignZero=1. Next state IWB.
- IWB: RegDst=0, MemtoReg=0, RegWrite=1, InstrDone=1. Next state FETCH.
- JUMP: PCSource=10, PCEn=1, InstrDone=1. Next state FETCH.
- Unused encodings (12–15) go to FETCH next cycle with all outputs 0.
- Cycle counts with MemReady tied high: R 4, lw 5, sw 4, bne 3, j 3, xori 4.
- Each wait on MemReady adds 1 cycle per low cycle.
- MemRead and MemWrite are never asserted in the same cycle.
- RegWrite and PCEn are never asserted outside the states listed above.

Optional Feature:
- Macro: MULTICYCLE_CTRL_PERF_EN.
- When defined:
  - Adds outputs CycleCnt[PERF_W] (increments every cycle after reset) and RetireCnt[PERF_W] (increments on InstrDone).
  - Both wrap to 0 at all-ones and reset to 0 on rst_n=0.
- When undefined: neither port nor any counter logic exists.

Test Plan:
- Reset then R-type, MemReady=1 -> states FETCH, DECODE, EXEC, RWB; RegWrite=1 and RegDst=1 in cycle 4 only; InstrDone pulses once.
- lw with MemReady low for 2 cycles in MEMRD -> MemRead/IorD=1 held 3 cycles; MEMWB has MemtoReg=1, RegWrite=1; total 7 cycles.
- bne with Zero=0 -> PCEn=1, PCSource=01 in cycle 3; repeat with Zero=1 -> PCEn=0; both return to FETCH.
- xori 001110 -> IEXEC has ALUOp=11, SignZero=1, ALUSrcB=10; IWB RegWrite=1, RegDst=0.
- Opcode 111111 -> IllegalOp pulse in DECODE; FETCH next; no RegWrite, MemWrite or PCEn beyond fetch.
- rst_n dropped during MEMWR wait -> all outputs 0 immediately; after release FETCH with MemRead=1; with the macro defined, CycleCnt and RetireCnt read 0.
